// File: rtl/mccoy_core.sv
// Accumulator core: FETCH accepts one instruction, EXEC retires it; 2 cycles per instruction.
// Backpressure: instr_ready is high only in FETCH and is low while reset is high.
module mccoy_core #(
   parameter int DATA_W = 8,
   parameter int REG_AW = 3,
   parameter int PC_W   = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [3+REG_AW-1:0]   instr,
   input  logic                  instr_valid,
   output logic                  instr_ready,
   output logic [PC_W-1:0]       pc,
   output logic [DATA_W-1:0]     x8,
   output logic                  carry,
   output logic                  retire
);

   localparam int NREGS = 2**REG_AW;

   typedef enum logic {FETCH, EXEC} state_t;

   state_t               state, state_nxt;
   logic [3+REG_AW-1:0]  ir;
   logic [DATA_W-1:0]    regs [NREGS];

   logic [2:0]           ir_op;
   logic [REG_AW-1:0]    ir_a;
   logic [DATA_W-1:0]    rd, imm;
   logic [DATA_W:0]      sum_r, sum_i;

   logic [PC_W-1:0]      pc_nxt;
   logic [DATA_W-1:0]    x8_nxt;
   logic                 carry_nxt;
   logic                 reg_wr;

   assign ir_op = ir[2:0];
   assign ir_a  = ir[3+REG_AW-1:3];
   assign rd    = regs[ir_a];
   assign imm   = DATA_W'(ir_a);
   assign sum_r = {1'b0, x8} + {1'b0, rd};
   assign sum_i = {1'b0, x8} + {1'b0, imm};

   assign instr_ready = (state == FETCH) && !reset;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= FETCH;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         FETCH:   if (instr_valid) state_nxt = EXEC;
         EXEC:    state_nxt = FETCH;
         default: state_nxt = FETCH;
      endcase
   end

   always_comb begin
      x8_nxt    = x8;
      carry_nxt = carry;
      pc_nxt    = pc + PC_W'(1);
      reg_wr    = 1'b0;
      case (ir_op)
         3'd0: {carry_nxt, x8_nxt} = sum_r;
         3'd1: {carry_nxt, x8_nxt} = sum_i;
         3'd2: x8_nxt = ~(x8 & rd);
         3'd3: x8_nxt = rd;
         3'd4: reg_wr = 1'b1;
         3'd5: x8_nxt = imm;
         3'd6: if (x8 == '0) pc_nxt = PC_W'(rd);
         3'd7: pc_nxt = PC_W'(x8);
         default: ;
      endcase
   end

   // Architectural state only moves on the edge that ends EXEC.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ir     <= '0;
         pc     <= '0;
         x8     <= '0;
         carry  <= 1'b0;
         retire <= 1'b0;
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else begin
         retire <= 1'b0;
         if (state == FETCH && instr_valid) ir <= instr;
         if (state == EXEC) begin
            pc     <= pc_nxt;
            x8     <= x8_nxt;
            carry  <= carry_nxt;
            retire <= 1'b1;
            if (reg_wr) regs[ir_a] <= x8;
         end
      end
   end

endmodule

// File: tb/tb_mccoy_core.sv
// Directed table-driven bench for mccoy_core (DATA_W=8, REG_AW=3, PC_W=8).
module tb_mccoy_core;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] instr;
   logic       instr_valid;
   logic       instr_ready;
   logic [7:0] pc;
   logic [7:0] x8;
   logic       carry;
   logic       retire;

   int ntests = 0;
   int nfail  = 0;
   int nret   = 0;

   mccoy_core #(.DATA_W(8), .REG_AW(3), .PC_W(8)) dut (
      .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .pc(pc), .x8(x8), .carry(carry), .retire(retire)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] op;
      logic [2:0] a;
      logic [7:0] x8;
      logic       c;
      logic [7:0] pc;
   } vec_t;

   vec_t vecs [26];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called at a negedge in FETCH; returns at the negedge after retire goes high.
   // During EXEC the instruction bus carries random junk that must be ignored.
   task automatic do_instr(input logic [2:0] op, input logic [2:0] a);
      instr       = {a, op};
      instr_valid = 1'b1;
      @(negedge clk);
      chk("exec_ready_low", {31'd0, instr_ready}, 32'd0);
      chk("exec_no_retire", {31'd0, retire}, 32'd0);
      instr       = 6'($urandom);
      instr_valid = 1'($urandom);
      @(negedge clk);
      instr_valid = 1'b0;
      if (retire) nret++;
      chk("retire_pulse", {31'd0, retire}, 32'd1);
   endtask

   task automatic chk_state(input string tag, input logic [7:0] ex, input logic ec, input logic [7:0] ep);
      chk({tag, "_x8"}, {24'd0, x8}, {24'd0, ex});
      chk({tag, "_carry"}, {31'd0, carry}, {31'd0, ec});
      chk({tag, "_pc"}, {24'd0, pc}, {24'd0, ep});
   endtask

   initial begin
      vecs[0]  = '{3'd5, 3'd5, 8'h05, 1'b0, 8'h01}; // LI 5
      vecs[1]  = '{3'd4, 3'd2, 8'h05, 1'b0, 8'h02}; // ST r2
      vecs[2]  = '{3'd1, 3'd7, 8'h0C, 1'b0, 8'h03}; // ADDI 7
      vecs[3]  = '{3'd0, 3'd2, 8'h11, 1'b0, 8'h04}; // ADD r2
      vecs[4]  = '{3'd3, 3'd2, 8'h05, 1'b0, 8'h05}; // LD r2
      vecs[5]  = '{3'd5, 3'd0, 8'h00, 1'b0, 8'h06}; // LI 0
      vecs[6]  = '{3'd2, 3'd0, 8'hFF, 1'b0, 8'h07}; // NAND r0
      vecs[7]  = '{3'd1, 3'd1, 8'h00, 1'b1, 8'h08}; // ADDI 1
      vecs[8]  = '{3'd5, 3'd3, 8'h03, 1'b1, 8'h09}; // LI 3
      vecs[9]  = '{3'd5, 3'd4, 8'h04, 1'b1, 8'h0A}; // LI 4
      vecs[10] = '{3'd1, 3'd4, 8'h08, 1'b0, 8'h0B}; // ADDI 4
      vecs[11] = '{3'd1, 3'd7, 8'h0F, 1'b0, 8'h0C};
      vecs[12] = '{3'd1, 3'd7, 8'h16, 1'b0, 8'h0D};
      vecs[13] = '{3'd1, 3'd7, 8'h1D, 1'b0, 8'h0E};
      vecs[14] = '{3'd1, 3'd3, 8'h20, 1'b0, 8'h0F};
      vecs[15] = '{3'd4, 3'd3, 8'h20, 1'b0, 8'h10}; // ST r3
      vecs[16] = '{3'd5, 3'd0, 8'h00, 1'b0, 8'h11}; // LI 0
      vecs[17] = '{3'd6, 3'd3, 8'h00, 1'b0, 8'h20}; // BEZ r3 taken
      vecs[18] = '{3'd5, 3'd1, 8'h01, 1'b0, 8'h21}; // LI 1
      vecs[19] = '{3'd6, 3'd3, 8'h01, 1'b0, 8'h22}; // BEZ r3 not taken
      vecs[20] = '{3'd7, 3'd0, 8'h01, 1'b0, 8'h01}; // JA
      vecs[21] = '{3'd5, 3'd7, 8'h07, 1'b0, 8'h02}; // LI 7
      vecs[22] = '{3'd4, 3'd4, 8'h07, 1'b0, 8'h03}; // ST r4
      vecs[23] = '{3'd2, 3'd4, 8'hF8, 1'b0, 8'h04}; // NAND r4
      vecs[24] = '{3'd0, 3'd4, 8'hFF, 1'b0, 8'h05}; // ADD r4
      vecs[25] = '{3'd0, 3'd4, 8'h06, 1'b1, 8'h06}; // ADD r4, carry out

      reset = 1'b1; instr = '0; instr_valid = 1'b1;
      repeat (3) @(negedge clk);
      chk_state("rst", 8'h00, 1'b0, 8'h00);
      chk("rst_ready", {31'd0, instr_ready}, 32'd0);
      chk("rst_retire", {31'd0, retire}, 32'd0);
      reset = 1'b0; instr_valid = 1'b0;
      #1 chk("rel_ready", {31'd0, instr_ready}, 32'd1);

      for (int i = 0; i < 26; i++) begin
         if (i == 0) nret = 0;
         do_instr(vecs[i].op, vecs[i].a);
         chk_state($sformatf("vec%0d", i), vecs[i].x8, vecs[i].c, vecs[i].pc);
         if (i == 3) chk("four_retires", nret, 4);
      end

      // Idle in FETCH: nothing may move.
      instr = {3'd5, 3'd1};
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("idle_ready", {31'd0, instr_ready}, 32'd1);
         chk_state("idle", 8'h06, 1'b1, 8'h06);
         chk("idle_retire", {31'd0, retire}, 32'd0);
      end

      // Bus toggling during EXEC must not change the latched LI 2.
      do_instr(3'd5, 3'd2);
      chk_state("latch", 8'h02, 1'b1, 8'h07);

      // Reset during the EXEC cycle of ST r1 aborts it.
      do_instr(3'd5, 3'd6);
      chk_state("li6", 8'h06, 1'b1, 8'h08);
      instr = {3'd1, 3'd4}; instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      reset = 1'b1;
      #1 chk_state("abort", 8'h00, 1'b0, 8'h00);
      chk("abort_ready", {31'd0, instr_ready}, 32'd0);
      @(negedge clk);
      chk("abort_retire", {31'd0, retire}, 32'd0);
      chk("abort_ready2", {31'd0, instr_ready}, 32'd0);
      reset = 1'b0;
      #1 chk("rel2_ready", {31'd0, instr_ready}, 32'd1);
      chk("rel2_retire", {31'd0, retire}, 32'd0);
      do_instr(3'd3, 3'd1);              // LD r1 must read 0
      chk_state("ld_r1", 8'h00, 1'b0, 8'h01);
      do_instr(3'd5, 3'd0);
      do_instr(3'd2, 3'd0);              // x8 = 0xFF
      do_instr(3'd7, 3'd0);              // JA -> 0xFF
      chk_state("ja_ff", 8'hFF, 1'b0, 8'hFF);
      do_instr(3'd5, 3'd0);              // LI 0, pc wraps
      chk_state("wrap", 8'h00, 1'b0, 8'h00);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule

// File: doc/mccoy_core.md
MCCOY_CORE -- requirements
Module: mccoy_core

Interface
REQ-001 Parameter DATA_W, default 8, accumulator (x8) and register width; legal range 4..16.
REQ-002 Parameter REG_AW, default 3, register address width; register count NREGS = 2**REG_AW.
REQ-003 Parameter PC_W, default 8, program counter width.
REQ-004 Port clk  input  1  single clock; all state updates on posedge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port instr  input  3+REG_AW  instruction word: [2:0] opcode, [3+REG_AW-1:3] operand field a.
REQ-007 Port instr_valid  input  1  instr holds a valid instruction.
REQ-008 Port instr_ready  output  1  core accepts instr this cycle.
REQ-009 Port pc  output  PC_W  address of the next instruction to fetch.
REQ-010 Port x8  output  DATA_W  accumulator value.
REQ-011 Port carry  output  1  carry flag.
REQ-012 Port retire  output  1  one-cycle pulse on instruction completion.

Function
REQ-013 Two-state FSM: FETCH, EXEC; state after reset is FETCH.
REQ-014 FETCH: instr_ready=1; on instr_valid=1, latch instr, go to EXEC; on instr_valid=0, stay, hold all state.
REQ-015 EXEC: instr_ready=0; execute latched instruction; at the clock edge ending EXEC, update registers, pc and flags, assert retire for the following cycle, return to FETCH.
REQ-016 Throughput: 2 cycles per instruction minimum; instr and instr_valid ignored while in EXEC.
REQ-017 Immediate imm = a, zero-extended to DATA_W.
REQ-018 000 ADD: {carry,x8} <= x8 + R[a], full DATA_W+1-bit sum.
REQ-019 001 ADDI: {carry,x8} <= x8 + imm.
REQ-020 010 NAND: x8 <= ~(x8 & R[a]); carry unchanged.
REQ-021 011 LD: x8 <= R[a]. 100 ST: R[a] <= x8. 101 LI: x8 <= imm. Carry unchanged for all three.
REQ-022 110 BEZ: if x8==0, pc <= R[a]; else pc <= pc+1.
REQ-023 111 JA: pc <= x8.
REQ-024 All other opcodes: pc <= pc+1.
REQ-025 Width rule: any DATA_W value loaded into pc is zero-extended or truncated to PC_W bits.
REQ-026 pc+1 wraps modulo 2**PC_W; x8 arithmetic wraps modulo 2**DATA_W, with overflow captured only in carry.
REQ-027 Register file: NREGS x DATA_W, written only by ST in EXEC; reads combinational from the latched operand.
REQ-028 Outputs pc, x8 and carry are registered; they change only at the edge ending EXEC.

Reset
REQ-029 Reset asserted: FSM=FETCH, pc=0, x8=0, carry=0, retire=0, all R[i]=0, latched instruction cleared; instr_ready=0 while reset is high.
REQ-030 Reset asserted during EXEC aborts the instruction: no register write, no pc or flag update, no retire pulse.
REQ-031 First fetch is accepted on the first posedge after reset deasserts with instr_valid=1.

Verification (DATA_W=8, REG_AW=3, PC_W=8)
REQ-032 Reset pulse mid-run -> pc=0x00, x8=0x00, carry=0, retire=0, instr_ready=0 during reset and 1 in the first cycle after release.
REQ-033 LI 5, ST r2, ADDI 7, ADD r2 -> x8=0x11, R2=0x05, pc=0x04, carry=0, exactly 4 retire pulses in 8 cycles.
REQ-034 LI 0, NAND r0, ADDI 1 -> NAND gives x8=0xFF; ADDI gives x8=0x00, carry=1; a subsequent LI 3 leaves carry=1.
REQ-035 LI 4, ADDI 4 (0x08), ADDI 7 (0x0F), ADDI 7 (0x16), ADDI 7 (0x1D), ADDI 3 (0x20), ST r3, LI 0, BEZ r3 -> pc=0x20; then LI 1, BEZ r3 -> pc=0x22.
REQ-036 Hold instr_valid=0 for 5 cycles in FETCH -> no state change, instr_ready=1 throughout; toggle instr during EXEC -> executed instruction is the one latched in FETCH.
REQ-037 LI 6, ST r1 with reset asserted in the ST EXEC cycle -> R1=0x00, x8=0x00, no retire pulse; pc=0xFF, then a NOP-class fetch -> pc wraps to 0x00.
